// File: rtl/trace_pkg.sv
// Shared encodings for the position trace buffer: capture modes and FSM states.
package trace_pkg;

  typedef enum logic [1:0] {
    MODE_SAMPLE_ALL = 2'b00,
    MODE_ON_CHANGE  = 2'b01,
    MODE_STOP_FULL  = 2'b10,
    MODE_RESERVED   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_TRIG = 2'b01,
    CAPTURE   = 2'b10,
    DONE      = 2'b11
  } state_e;

  // Every mode except STOP_FULL replaces the oldest entry once the ring is full
  function automatic logic is_wrap_mode(input logic [1:0] m);
    return (m != MODE_STOP_FULL);
  endfunction

endpackage

// File: rtl/trace_ring_mem.sv
// Circular entry store for the trace buffer: write port, registered read port,
// read/write pointers and occupancy count, with optional overwrite of the oldest entry.
module trace_ring_mem #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic                     overwrite_ok,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     wr_accept,
  output logic                     overwrote,
  output logic                     fill_event
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_fire;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Decide which operations actually happen this cycle; a clear suppresses both ports
  always_comb begin
    rd_fire    = rd_en & ~empty & ~clr;
    wr_accept  = wr_en & ~clr & (~full | rd_fire | overwrite_ok);
    overwrote  = wr_accept & full & ~rd_fire;
    fill_event = wr_accept & (count_d == CNT_W'(DEPTH));
  end

  // Next-state for storage, pointers, count and the registered read port
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (rd_fire) begin
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
      if (wr_accept) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (rd_fire | overwrote) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_accept & ~overwrote, rd_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Register storage and control state; everything clears on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;

endmodule

// File: rtl/pos_trace_buffer.sv
// Game-state trace capture: samples NUM_CH channels on sample_en, tags each with a
// free-running timestamp and stores it in a ring drained through a read port.
// Define TRACE_TRIGGER_EN to add a ch0 value/mask trigger that gates the start of capture.
module pos_trace_buffer
  import trace_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 8,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH*CH_W-1:0]        ch_data,
  input  logic                          sample_en,
  input  logic                          arm,
  input  logic [1:0]                    mode,
  input  logic                          rd_en,
`ifdef TRACE_TRIGGER_EN
  input  logic [CH_W-1:0]               trig_value,
  input  logic [CH_W-1:0]               trig_mask,
`endif
  output logic [NUM_CH*CH_W+TS_W-1:0]   rd_data,
  output logic                          rd_valid,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          empty,
  output logic                          full,
  output logic                          overflow,
  output logic                          capturing
);

  localparam int CH_TOT = NUM_CH * CH_W;
  localparam int DATA_W = CH_TOT + TS_W;

  state_e            state_q, state_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              first_q, first_d;
  logic [CH_TOT-1:0] last_q, last_d;
  logic              overflow_q, overflow_d;

  logic              stop_full;
  logic              on_change;
  logic              capture_window;
  logic              qualify;
  logic              trig_hit;
  logic              wr_accept;
  logic              overwrote;
  logic              fill_event;

  // Decode mode and build the write qualifier; arm always wins over a same-cycle sample
  always_comb begin
    stop_full = (mode == MODE_STOP_FULL);
    on_change = (mode == MODE_ON_CHANGE);
`ifdef TRACE_TRIGGER_EN
    trig_hit  = sample_en & ((ch_data[CH_W-1:0] & trig_mask) == (trig_value & trig_mask));
    capture_window = (state_q == CAPTURE) | ((state_q == WAIT_TRIG) & trig_hit);
`else
    trig_hit  = 1'b0;
    capture_window = (state_q == CAPTURE);
`endif
    qualify = capture_window & sample_en & ~arm &
              (~on_change | first_q | (ch_data != last_q));
  end

  trace_ring_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ring (
    .clk          (clk),
    .reset        (reset),
    .clr          (arm),
    .wr_en        (qualify),
    .overwrite_ok (is_wrap_mode(mode)),
    .wr_data      ({ts_q, ch_data}),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .wr_accept    (wr_accept),
    .overwrote    (overwrote),
    .fill_event   (fill_event)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: arm restarts from any state, STOP_FULL ends capture on the filling write
  always_comb begin
    state_d = state_q;
    if (arm) begin
`ifdef TRACE_TRIGGER_EN
      state_d = WAIT_TRIG;
`else
      state_d = CAPTURE;
`endif
    end else begin
      case (state_q)
        WAIT_TRIG: begin
          if (trig_hit) begin
            state_d = (stop_full & fill_event) ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (stop_full & fill_event) begin
            state_d = DONE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    capturing = (state_q == CAPTURE);
  end

  // Timestamp, change-detect history and sticky overflow next-state
  always_comb begin
    ts_d       = ts_q + 1'b1;
    first_d    = first_q;
    last_d     = last_q;
    overflow_d = overflow_q;
    if (arm) begin
      first_d    = 1'b1;
      overflow_d = 1'b0;
    end else if (wr_accept) begin
      first_d = 1'b0;
      last_d  = ch_data;
      if (overwrote) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Register timestamp and capture bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_q       <= '0;
      first_q    <= 1'b0;
      last_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      first_q    <= first_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_pos_trace_buffer.sv
// Directed self-checking bench for pos_trace_buffer with a queue scoreboard of stored entries.
module tb_pos_trace_buffer;

  localparam int NUM_CH = 2;
  localparam int CH_W   = 8;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 16;
  localparam int DATA_W = NUM_CH * CH_W + TS_W;

  logic                        clk;
  logic                        reset;
  logic [NUM_CH*CH_W-1:0]      ch_data;
  logic                        sample_en;
  logic                        arm;
  logic [1:0]                  mode;
  logic                        rd_en;
`ifdef TRACE_TRIGGER_EN
  logic [CH_W-1:0]             trig_value;
  logic [CH_W-1:0]             trig_mask;
`endif
  logic [DATA_W-1:0]           rd_data;
  logic                        rd_valid;
  logic [$clog2(DEPTH):0]      count;
  logic                        empty;
  logic                        full;
  logic                        overflow;
  logic                        capturing;

  int n_assert = 0;
  int n_fail   = 0;

  // Scoreboard / reference model
  logic [DATA_W-1:0]      mq [$];
  logic [DATA_W-1:0]      last_rd;
  logic [NUM_CH*CH_W-1:0] last_ch;
  logic                   m_first;
  logic                   m_ovf;
  int                     m_state;   // 0 idle, 1 wait-trigger, 2 capture, 3 done
  logic [TS_W-1:0]        tb_ts;

  pos_trace_buffer #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .DEPTH  (DEPTH),
    .TS_W   (TS_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ch_data    (ch_data),
    .sample_en  (sample_en),
    .arm        (arm),
    .mode       (mode),
    .rd_en      (rd_en),
`ifdef TRACE_TRIGGER_EN
    .trig_value (trig_value),
    .trig_mask  (trig_mask),
`endif
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .capturing  (capturing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent timestamp reference: counts clocks since reset release
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_ts <= '0;
    else        tb_ts <= tb_ts + 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input logic exp_rv, input logic [DATA_W-1:0] exp_rd);
    checkOutput("rd_valid",  64'(rd_valid),  64'(exp_rv));
    checkOutput("rd_data",   64'(rd_data),   64'(exp_rd));
    checkOutput("count",     64'(count),     64'(mq.size()));
    checkOutput("empty",     64'(empty),     64'(mq.size() == 0));
    checkOutput("full",      64'(full),      64'(mq.size() == DEPTH));
    checkOutput("overflow",  64'(overflow),  64'(m_ovf));
    checkOutput("capturing", 64'(capturing), 64'(m_state == 2));
  endtask

  task automatic modelReset();
    mq.delete();
    last_rd = '0;
    last_ch = '0;
    m_first = 1'b0;
    m_ovf   = 1'b0;
    m_state = 0;
  endtask

  // Drive one cycle of stimulus, advance the model, then check the DUT after the edge
  task automatic applyStimulus(input logic s, input logic [NUM_CH*CH_W-1:0] ch,
                               input logic r, input logic a);
    logic              rd_fire;
    logic              wq;
    logic [DATA_W-1:0] exp_rd;
    @(negedge clk);
    sample_en = s;
    ch_data   = ch;
    rd_en     = r;
    arm       = a;
    rd_fire   = 1'b0;
    exp_rd    = last_rd;
    if (a) begin
      mq.delete();
      m_first = 1'b1;
      m_ovf   = 1'b0;
`ifdef TRACE_TRIGGER_EN
      m_state = 1;
`else
      m_state = 2;
`endif
    end else begin
      rd_fire = r && (mq.size() > 0);
      if (m_state == 1 && s) m_state = 2;
      wq = (m_state == 2) && s && (mode != 2'b01 || m_first || ch != last_ch);
      if (wq && mode == 2'b10 && mq.size() == DEPTH && !rd_fire) wq = 1'b0;
      if (rd_fire) begin
        exp_rd  = mq.pop_front();
        last_rd = exp_rd;
      end
      if (wq) begin
        if (mq.size() == DEPTH) begin
          void'(mq.pop_front());
          m_ovf = 1'b1;
        end
        mq.push_back({tb_ts, ch});
        last_ch = ch;
        m_first = 1'b0;
        if (mode == 2'b10 && mq.size() == DEPTH) m_state = 3;
      end
    end
    @(posedge clk);
    #1;
    checkState(rd_fire, exp_rd);
  endtask

  initial begin
    reset     = 1'b0;
    ch_data   = '0;
    sample_en = 1'b0;
    arm       = 1'b0;
    mode      = 2'b00;
    rd_en     = 1'b0;
`ifdef TRACE_TRIGGER_EN
    trig_value = '0;
    trig_mask  = '0;
`endif
    modelReset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkState(1'b0, '0);
    @(negedge clk);
    reset = 1'b1;

    // Samples before any arm are ignored
    applyStimulus(1'b1, 16'h1111, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0);

    // SAMPLE_ALL: three samples then three pops, plus one pop while empty
    mode = 2'b00;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h0201, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0302, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0403, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

    // ON_CHANGE: repeated values are dropped
    mode = 2'b01;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h0505, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0505, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0506, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0506, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

    // Wrap: 18 samples into 16 entries sets overflow, oldest two lost
    mode = 2'b00;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 18; i++) applyStimulus(1'b1, 16'(i), 1'b0, 1'b0);
    repeat (16) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

    // STOP_FULL: capture halts on the 16th write, re-arm clears everything
    mode = 2'b10;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

    // Full in SAMPLE_ALL with simultaneous pop and push: no overflow
    mode = 2'b00;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 16'(16'h0A00 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hABCD, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'hBCDE, 1'b1, 1'b0);
    repeat (16) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

    // Reset mid-capture with five entries stored
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'(16'h0C00 + i), 1'b0, 1'b0);
    @(negedge clk);
    sample_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    checkState(1'b0, '0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b1, 16'h0D0D, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h0E0E, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pos_trace_buffer.md
Name: pos_trace_buffer

Overview:
Synthesizable, parametrised capture buffer for game-state channels such as the falling-block y positions. It samples NUM_CH channels on a qualifying tick, tags each sample with a timestamp, and stores it in a circular buffer. The buffer is drained through a simple read port. It sits beside the game processor inside the VGA/game top and is read by a debug/LED or UART path.

Parameters:
NUM_CH, 2, number of watched channels
CH_W, 8, width of each channel
DEPTH, 16, buffer entries; power of two, minimum 2
TS_W, 16, timestamp counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
ch_data  in  NUM_CH*CH_W  packed channels, ch0 in LSBs
sample_en  in  1  sample tick (e.g. gravity/frame strobe)
arm  in  1  one-cycle pulse: clear buffer, start capture
mode  in  2  00 SAMPLE_ALL, 01 ON_CHANGE, 10 STOP_FULL, 11 reserved (treated as 00)
rd_en  in  1  pop request
rd_data  out  NUM_CH*CH_W+TS_W  {timestamp, channels}
rd_valid  out  1  rd_data valid, single-cycle pulse
count  out  $clog2(DEPTH)+1  stored entries
empty  out  1  count==0
full  out  1  count==DEPTH
overflow  out  1  sticky: an entry was overwritten
capturing  out  1  FSM in CAPTURE

Behaviour:
- Reset (reset==0, async) clears all registers. Outputs on reset: rd_data=0, rd_valid=0, count=0, empty=1, full=0, overflow=0, capturing=0, FSM=IDLE, timestamp=0.
- Timestamp is free-running and increments every clk. It wraps 2^TS_W-1 -> 0 without any flag.
- FSM states IDLE, CAPTURE, DONE:
  - IDLE -arm-> CAPTURE.
  - CAPTURE -(mode==STOP_FULL and write makes count==DEPTH)-> DONE.
  - DONE -arm-> CAPTURE.
  - arm in any state: pointers=0, count=0, overflow=0, first_flag=1; takes effect on the next cycle.
  - arm in the same cycle as sample_en: arm wins, no write that cycle.
- Write qualifier (CAPTURE only): sample_en AND (mode!=ON_CHANGE OR first_flag OR ch_data!=last_written).
  - Entry stored = {timestamp at that edge, ch_data}.
  - last_written is updated on every write; first_flag clears after the first write.
- Full handling:
  - SAMPLE_ALL/ON_CHANGE while full: the write overwrites the oldest entry; rd_ptr advances; count stays DEPTH; overflow set.
  - STOP_FULL: the write that fills the buffer moves the FSM to DONE; further samples are ignored.
- Read: rd_en with !empty -> rd_data registered, rd_valid=1 the next cycle, rd_ptr++, count--.
  - rd_en while empty: ignored; rd_valid=0; rd_data holds its last value.
- Simultaneous read and write:
  - Not full: pop the oldest, push the new; count unchanged.
  - Full, wrap modes: the pop returns the oldest entry and the push lands in the freed slot; count=DEPTH; overflow not set.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally.
- Reading in any FSM state is legal; capture continues during reads.

Optional Feature:
TRACE_TRIGGER_EN
- Defined:
  - Adds ports trig_value in CH_W and trig_mask in CH_W.
  - After arm, the FSM enters WAIT_TRIG (capturing=0).
  - It moves to CAPTURE on the first sample_en where (ch0 & trig_mask)==(trig_value & trig_mask).
  - The triggering sample is the first entry stored.
- Undefined: no extra ports; arm goes directly to CAPTURE.

Decomposition:
- Package trace_pkg:
  - mode encodings MODE_SAMPLE_ALL/MODE_ON_CHANGE/MODE_STOP_FULL.
  - FSM state encodings (IDLE, WAIT_TRIG, CAPTURE, DONE).
- One sub-module, trace_ring_mem:
  - DEPTH x (NUM_CH*CH_W+TS_W) storage.
  - Write port, registered read port, wr/rd pointers, and count.
  - Overwrite-oldest input.
- The top holds the FSM, timestamp, change detect, and qualifier logic.

Test Plan:
- Reset low mid-capture with 5 entries stored -> immediately count=0, empty=1, rd_valid=0, capturing=0. After release, arm is required to capture.
- Defaults, SAMPLE_ALL: arm, then 3 sample_en with ch_data 0x0201, 0x0302, 0x0403 -> count=3. Three pops return those values in order, timestamps strictly increasing, rd_valid one cycle after each rd_en.
- ON_CHANGE: samples 0x0505, 0x0505, 0x0506, 0x0506 -> count=2; entries are 0x0505 then 0x0506.
- Wrap: SAMPLE_ALL, 18 samples of values 0..17, DEPTH=16 -> count=16, overflow=1, first pop=2, last pop=17.
- STOP_FULL: 20 samples -> count=16, capturing=0 after the 16th; the 17th-20th are ignored. arm -> count=0, capturing=1, overflow=0.
- Simultaneous rd_en and sample_en with the buffer full in SAMPLE_ALL -> count stays 16, overflow stays 0, popped value is the oldest.
